// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - waits for both operand vectors, strobes N reads, MACs the returned pairs
// Result and valid flag are held until the next start is accepted.
module dot_product_engine #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              doneA,
  input  logic              doneB,
  input  logic [DATA_W-1:0] readDataA,
  input  logic [DATA_W-1:0] readDataB,
  output logic              RD_EN,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_READ,
    S_DRAIN
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_rd_en;
  logic               r_rd_d;
  logic               r_busy;
  logic [ACC_W-1:0]   r_result;
  logic               r_result_valid;

  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;

  assign w_prod = readDataA * readDataB;
  assign w_sum  = r_acc + ACC_W'(w_prod);

  // r_rd_d tags the cycle in which the input stage presents the pair for last cycle's strobe
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_rd_en        <= 1'b0;
      r_rd_d         <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_rd_d <= r_rd_en;
      if (r_rd_d) begin
        r_acc <= w_sum;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_WAIT_LOAD;
            r_busy         <= 1'b1;
            r_result_valid <= 1'b0;
          end
        end
        S_WAIT_LOAD: begin
          if (doneA && doneB) begin
            r_state <= S_READ;
            r_rd_en <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Final pair is still in flight here, so fold it straight into the result
          r_result       <= w_sum;
          r_result_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RD_EN        = r_rd_en;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - table-driven and random checks of dot_product_engine
// Includes a small input-stage model with a wrapping shared read pointer.
module tb_dot_product_engine;
  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 19;

  logic              CLK;
  logic              RST_N;
  logic              start;
  logic              doneA;
  logic              doneB;
  logic [DATA_W-1:0] readDataA;
  logic [DATA_W-1:0] readDataB;
  logic              RD_EN;
  logic              busy;
  logic [ACC_W-1:0]  result;
  logic              result_valid;

  dot_product_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .doneA(doneA), .doneB(doneB),
    .readDataA(readDataA), .readDataB(readDataB), .RD_EN(RD_EN), .busy(busy),
    .result(result), .result_valid(result_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DATA_W-1:0] mem_a [N];
  logic [DATA_W-1:0] mem_b [N];
  int ptr;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr       <= 0;
      readDataA <= '0;
      readDataB <= '0;
    end else if (RD_EN) begin
      readDataA <= mem_a[ptr];
      readDataB <= mem_b[ptr];
      ptr       <= (ptr + 1) % N;
    end
  end

  typedef struct {
    logic [N-1:0][DATA_W-1:0] a;
    logic [N-1:0][DATA_W-1:0] b;
    int exp;
    int dly;
    bit mid;
    int exp_fa;
    int exp_fb;
  } vec_t;

  vec_t tbl [7];
  int n_cmp = 0;
  int n_fail = 0;
  int last_fa, last_fb;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dot_ref();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(mem_a[i]) * int'(mem_b[i]);
    return s;
  endfunction

  task automatic run(input string name, input int exp, input int dly, input bit mid,
                     input int exp_fa, input int exp_fb);
    int cyc, strobes;
    bit early;
    @(negedge CLK);
    doneA = 1'b1;
    doneB = (dly == 0);
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    cyc = 0; strobes = 0; early = 0;
    last_fa = -1; last_fb = -1;
    while (!result_valid && cyc < 60) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      if (RD_EN) strobes++;
      if (RD_EN && cyc <= dly) early = 1;
      if (cyc == dly) doneB = 1'b1;
      if (cyc == dly + 2) begin
        last_fa = int'(readDataA);
        last_fb = int'(readDataB);
      end
      if (mid) start = (cyc == dly + 4);
    end
    start = 1'b0;
    chk({name, " latency"}, cyc, 10 + dly);
    chk({name, " strobes"}, strobes, N);
    chk({name, " result"}, result, exp);
    chk({name, " busy_done"}, busy, 0);
    chk({name, " first_a"}, last_fa, exp_fa);
    chk({name, " first_b"}, last_fb, exp_fb);
    if (dly > 0) chk({name, " early_rd"}, early, 0);
    if (mid) begin
      repeat (4) @(negedge CLK);
      chk({name, " no_rerun_busy"}, busy, 0);
      chk({name, " no_rerun_valid"}, result_valid, 1);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = v.a[i];
      mem_b[i] = v.b[i];
    end
  endtask

  initial begin
    int cyc;
    RST_N = 1'b0; start = 1'b0; doneA = 1'b0; doneB = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tbl[i].dly = 0; tbl[i].mid = 0;
    end
    for (int i = 0; i < N; i++) begin
      tbl[0].a[i] = 8'(i + 1); tbl[0].b[i] = 8'd1;
      tbl[1].a[i] = 8'd255;    tbl[1].b[i] = 8'd255;
      tbl[2].a[i] = 8'(i + 1); tbl[2].b[i] = 8'd1;
      tbl[3].a[i] = 8'(i + 1); tbl[3].b[i] = 8'd2;
      tbl[4].a[i] = 8'(i + 1); tbl[4].b[i] = 8'(8 - i);
      tbl[5].a[i] = 8'(i + 1); tbl[5].b[i] = 8'(8 - i);
      tbl[6].a[i] = 8'd0;      tbl[6].b[i] = 8'd200;
    end
    tbl[0].exp = 36;     tbl[0].exp_fa = 1;   tbl[0].exp_fb = 1;
    tbl[1].exp = 520200; tbl[1].exp_fa = 255; tbl[1].exp_fb = 255;
    tbl[2].exp = 36;     tbl[2].exp_fa = 1;   tbl[2].exp_fb = 1;   tbl[2].dly = 5;
    tbl[3].exp = 72;     tbl[3].exp_fa = 1;   tbl[3].exp_fb = 2;   tbl[3].mid = 1;
    tbl[4].exp = 120;    tbl[4].exp_fa = 1;   tbl[4].exp_fb = 8;
    tbl[5].exp = 120;    tbl[5].exp_fa = 1;   tbl[5].exp_fb = 8;
    tbl[6].exp = 0;      tbl[6].exp_fa = 0;   tbl[6].exp_fb = 200;

    repeat (2) @(negedge CLK);
    chk("rst RD_EN", RD_EN, 0);
    chk("rst busy", busy, 0);
    chk("rst result", result, 0);
    chk("rst valid", result_valid, 0);
    RST_N = 1'b1;

    for (int t = 0; t < 7; t++) begin
      load(tbl[t]);
      run($sformatf("vec%0d", t), tbl[t].exp, tbl[t].dly, tbl[t].mid,
          tbl[t].exp_fa, tbl[t].exp_fb);
    end

    // Reset in the 4th READ cycle
    load(tbl[0]);
    @(negedge CLK);
    doneA = 1'b1; doneB = 1'b1; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    while (cyc < 4) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end
    chk("pre_rst RD_EN", RD_EN, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst RD_EN", RD_EN, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst valid", result_valid, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst idle busy", busy, 0);
    chk("post_rst idle RD_EN", RD_EN, 0);
    run("post_rst", 36, 0, 0, 1, 1);

    for (int r = 0; r < 6; r++) begin
      int d;
      for (int i = 0; i < N; i++) begin
        mem_a[i] = 8'($urandom_range(0, 255));
        mem_b[i] = 8'($urandom_range(0, 255));
      end
      d = $urandom_range(0, 3);
      run($sformatf("rand%0d", r), dot_ref(), d, 0, int'(mem_a[0]), int'(mem_b[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
